// File: rtl/mic_capture_pkg.sv
// Shared constants for the microphone ping-pong capture block:
// CSR map, STATUS bit positions and capture FSM encoding.
package mic_capture_pkg;

  localparam int unsigned CSR_ADDR_W = 2;
  localparam int unsigned CSR_DATA_W = 32;

  localparam logic [CSR_ADDR_W-1:0] CSR_CTRL      = 2'd0;
  localparam logic [CSR_ADDR_W-1:0] CSR_STATUS    = 2'd1;
  localparam logic [CSR_ADDR_W-1:0] CSR_WORDCOUNT = 2'd2;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;

  localparam int unsigned STAT_HALF0_BIT   = 0;
  localparam int unsigned STAT_HALF1_BIT   = 1;
  localparam int unsigned STAT_OVERRUN_BIT = 2;
  localparam int unsigned STAT_ACTIVE_BIT  = 3;
  localparam int unsigned STAT_STATE_LSB   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2
  } cap_state_e;

  // Words per half of a buffer addressed by addr_w bits.
  function automatic int unsigned half_depth(input int unsigned addr_w);
    return 32'd1 << (addr_w - 1);
  endfunction

endpackage

// File: rtl/mic_capture_csr.sv
// CSR register file for the capture block: CTRL, W1C status flags,
// word count readback and the level interrupt.
module mic_capture_csr
  import mic_capture_pkg::*;
#(
  parameter int unsigned IDX_W = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CSR_ADDR_W-1:0] csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [CSR_DATA_W-1:0] csr_writedata,
  output logic [CSR_DATA_W-1:0] csr_readdata,
  input  logic [1:0]            set_half,
  input  logic                  set_overrun,
  input  logic                  active_half,
  input  cap_state_e            state,
  input  logic [IDX_W-1:0]      idx,
  output logic                  enable,
  output logic [1:0]            full,
  output logic                  irq
);

  logic [1:0]            ctrl_q, ctrl_d;
  logic [1:0]            full_q, full_d;
  logic                  ovr_q, ovr_d;
  logic                  irq_q, irq_d;
  logic [CSR_DATA_W-1:0] rdata_q, rdata_d;
  logic                  wr_ctrl_c, wr_stat_c;
  logic                  unused_wdata_c;

  assign unused_wdata_c = ^csr_writedata[CSR_DATA_W-1:3];

  // Hardware set has priority over a software clear of the same flag.
  always_comb begin
    wr_ctrl_c = csr_write && (csr_address == CSR_CTRL);
    wr_stat_c = csr_write && (csr_address == CSR_STATUS);

    ctrl_d = wr_ctrl_c ? csr_writedata[1:0] : ctrl_q;

    full_d[0] = set_half[0] |
                (full_q[0] & ~(wr_stat_c & csr_writedata[STAT_HALF0_BIT]));
    full_d[1] = set_half[1] |
                (full_q[1] & ~(wr_stat_c & csr_writedata[STAT_HALF1_BIT]));
    ovr_d     = set_overrun |
                (ovr_q & ~(wr_stat_c & csr_writedata[STAT_OVERRUN_BIT]));

    irq_d = ctrl_q[CTRL_IRQ_EN_BIT] & ((|full_q) | ovr_q);

    rdata_d = rdata_q;
    if (csr_read) begin
      case (csr_address)
        CSR_CTRL:      rdata_d = CSR_DATA_W'(ctrl_q);
        CSR_STATUS:    rdata_d = CSR_DATA_W'({state, active_half, ovr_q, full_q});
        CSR_WORDCOUNT: rdata_d = CSR_DATA_W'(idx);
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      full_q  <= '0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign enable       = ctrl_q[CTRL_ENABLE_BIT];
  assign full         = full_q;
  assign irq          = irq_q;
  assign csr_readdata = rdata_q;

endmodule

// File: rtl/mic_pingpong_writer.sv
// Writes a 32-bit sample stream into two halves of a dual-port RAM in
// ping-pong fashion, flagging each completed half to software.
module mic_pingpong_writer
  import mic_capture_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned HALF_DEPTH = half_depth(ADDR_W)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CSR_ADDR_W-1:0] csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [CSR_DATA_W-1:0] csr_writedata,
  output logic [CSR_DATA_W-1:0] csr_readdata,
  input  logic                  snk_valid,
  input  logic [DATA_W-1:0]     snk_data,
  output logic                  snk_ready,
  output logic [ADDR_W-1:0]     ram_address,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [3:0]            ram_byteenable,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  output logic                  irq
);

  localparam int unsigned IDX_W = ADDR_W - 1;

  cap_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                half_q, half_d;
  logic                ready_q, ready_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          set_half_q, set_half_d;
  logic                set_ovr_c;
  logic                accept_c;
  logic                enable;
  logic [1:0]          full;

  assign accept_c = snk_valid & ready_q;

  // Next-state, write pipeline capture and flag strobes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    half_d     = half_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    set_half_d = 2'b00;
    set_ovr_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d  = '0;
        half_d = 1'b0;
        if (enable) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept_c) begin
          wr_d   = 1'b1;
          addr_d = {half_q, idx_q};
          data_d = snk_data;
          if (idx_q == IDX_W'(HALF_DEPTH - 1)) begin
            idx_d              = '0;
            half_d             = ~half_q;
            set_half_d[half_q] = 1'b1;
            if (full[~half_q]) state_d = ST_WAIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT: begin
        set_ovr_c = accept_c;
        if (!full[half_q]) state_d = ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable abandons the partial half; a beat captured this cycle still writes.
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      half_d  = 1'b0;
    end

    ready_d = enable & (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      half_q     <= 1'b0;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      set_half_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      half_q     <= half_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      set_half_q <= set_half_d;
    end
  end

  mic_capture_csr #(
    .IDX_W (IDX_W)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .set_half      (set_half_q),
    .set_overrun   (set_ovr_c),
    .active_half   (half_q),
    .state         (state_q),
    .idx           (idx_q),
    .enable        (enable),
    .full          (full),
    .irq           (irq)
  );

  assign snk_ready      = ready_q;
  assign ram_address    = addr_q;
  assign ram_chipselect = wr_q;
  assign ram_write      = wr_q;
  assign ram_writedata  = data_q;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;

endmodule
